// File: rtl/dac_spi_12bit_pkg.sv
// Shared constants for the MCP4921-style SPI DAC transmitter: FSM encodings,
// frame geometry and the default frame header.
package dac_spi_12bit_pkg;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] LOAD  = 4'd1;
    localparam logic [3:0] SHIFT = 4'd2;
    localparam logic [3:0] DONE  = 4'd3;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;

    // A/B = 0 (DAC A), BUF = 0, GA = 1 (1x), SHDN = 1 (active)
    localparam logic [3:0] CFG_BITS_DEFAULT = 4'b0011;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] cfg,
                                                          input logic [DATA_BITS-1:0] value);
        return {cfg, value};
    endfunction

endpackage

// File: rtl/dac_spi_12bit.sv
// Continuous 16-bit SPI frame transmitter for a 12-bit DAC. SCK runs at half the
// system clock (mode 0); the input sample is captured once per frame in LOAD.
module dac_spi_12bit
    import dac_spi_12bit_pkg::*;
#(
    parameter logic [3:0]  CFG_BITS       = CFG_BITS_DEFAULT,
    parameter int unsigned CS_IDLE_CYCLES = 2
) (
    input  logic        clk12MHz,
    input  logic        rst,
    input  logic [11:0] digital_12bit_value,
    output logic        sdo,
    output logic        cs,
    output logic        sck,
    output logic [3:0]  debug_states,
    output logic        debug_sck_halfs
);

    logic [3:0]            state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            idle_cnt_q, idle_cnt_d;
    logic                  phase_q, phase_d;
    logic                  cs_q, cs_d;
    logic                  sck_q, sck_d;
    logic                  sdo_q, sdo_d;
    logic                  idle_last;

    assign idle_last = (32'(idle_cnt_q) + 32'd1) >= CS_IDLE_CYCLES;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        phase_d    = phase_q;
        cs_d       = cs_q;
        sck_d      = sck_q;
        sdo_d      = sdo_q;
        case (state_q)
            IDLE: begin
                cs_d    = 1'b1;
                sck_d   = 1'b0;
                sdo_d   = 1'b0;
                phase_d = 1'b0;
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d   = build_frame(CFG_BITS, digital_12bit_value);
                cs_d      = 1'b0;
                sck_d     = 1'b0;
                sdo_d     = CFG_BITS[3];
                bit_cnt_d = '0;
                phase_d   = 1'b0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                phase_d = ~phase_q;
                if (!phase_q) begin
                    sck_d = 1'b1;
                end else begin
                    // Falling SCK edge: present the next bit while the DAC is not sampling
                    sck_d     = 1'b0;
                    shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                        cs_d       = 1'b1;
                        sdo_d      = 1'b0;
                        idle_cnt_d = '0;
                        state_d    = DONE;
                    end else begin
                        sdo_d = shreg_q[FRAME_BITS-2];
                    end
                end
            end
            DONE: begin
                cs_d  = 1'b1;
                sck_d = 1'b0;
                sdo_d = 1'b0;
                if (idle_last) begin
                    state_d = LOAD;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            default: begin
                cs_d    = 1'b1;
                sck_d   = 1'b0;
                sdo_d   = 1'b0;
                phase_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk12MHz) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            phase_q    <= 1'b0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            sdo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            phase_q    <= phase_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            sdo_q      <= sdo_d;
        end
    end

    assign sdo             = sdo_q;
    assign cs              = cs_q;
    assign sck             = sck_q;
    assign debug_states    = state_q;
    assign debug_sck_halfs = phase_q;

endmodule

// File: tb/tb_dac_spi_12bit.sv
// Scoreboard bench for dac_spi_12bit: frames captured on SCK rising edges are
// compared with headers+samples queued when each sample is driven into LOAD.
`timescale 1ns/1ps
module tb_dac_spi_12bit;

    localparam logic [3:0]  CFG      = 4'b0011;
    localparam int unsigned CS_IDLE  = 2;
    localparam int unsigned PERIOD   = 35;
    localparam logic [3:0]  ST_IDLE  = 4'd0;
    localparam logic [3:0]  ST_LOAD  = 4'd1;
    localparam logic [3:0]  ST_SHIFT = 4'd2;
    localparam logic [3:0]  ST_DONE  = 4'd3;

    logic        clk12MHz = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] value = 12'h000;
    logic        sdo, cs, sck, debug_sck_halfs;
    logic [3:0]  debug_states;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    dac_spi_12bit dut (
        .clk12MHz            (clk12MHz),
        .rst                 (rst),
        .digital_12bit_value (value),
        .sdo                 (sdo),
        .cs                  (cs),
        .sck                 (sck),
        .debug_states        (debug_states),
        .debug_sck_halfs     (debug_sck_halfs)
    );

    always #5 clk12MHz = ~clk12MHz;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: samples on the falling clock edge, away from the active edge
    int          cyc = 0;
    int          last_fall = 0;
    bit          period_valid = 0;
    bit          gap_valid = 0;
    bit          in_frame = 0;
    int          rises = 0;
    int          glitch = 0;
    int          phase_err = 0;
    int          cs_high_cnt = 0;
    int          done_cnt = 0;
    int          rst_viol = 0;
    logic [15:0] frame = '0;
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_sdo = 1'b0, prev_rst = 1'b0;
    logic        prev_phase = 1'b0;
    logic [3:0]  prev_state = 4'd0;

    always @(negedge clk12MHz) begin
        cyc++;
        if (!rst) begin
            in_frame     = 0;
            period_valid = 0;
            gap_valid    = 0;
            if (!prev_rst && (cs !== 1'b1 || sck !== 1'b0 || sdo !== 1'b0 ||
                              debug_states !== ST_IDLE || debug_sck_halfs !== 1'b0))
                rst_viol++;
        end else begin
            if (prev_cs && !cs) begin
                if (period_valid) check("frame_period", cyc - last_fall, PERIOD);
                if (gap_valid) begin
                    // CS is high through DONE plus the LOAD cycle before the next frame
                    check("cs_high_gap", cs_high_cnt, CS_IDLE + 1);
                    check("done_cycles", done_cnt, CS_IDLE);
                end
                last_fall    = cyc;
                period_valid = 1;
                in_frame     = 1;
                rises        = 0;
                glitch       = 0;
                phase_err    = 0;
                frame        = '0;
            end
            if (in_frame && !cs) begin
                if (sck && !prev_sck) begin
                    frame = {frame[14:0], sdo};
                    rises++;
                end
                if (!prev_cs && sdo !== prev_sdo && !(prev_sck && !sck)) glitch++;
                if (debug_states == ST_SHIFT) begin
                    if (sck !== debug_sck_halfs) phase_err++;
                    if (prev_state == ST_SHIFT && debug_sck_halfs === prev_phase) phase_err++;
                end
            end
            if (cs && sck) phase_err++;
            if (!prev_cs && cs && in_frame) begin
                if (exp_q.size() == 0) begin
                    check("exp_avail", 0, 1);
                end else begin
                    check("frame_bits", frame, exp_q.pop_front());
                end
                check("sck_rises", rises, 16);
                check("sdo_glitch", glitch, 0);
                check("sck_phase", phase_err, 0);
                in_frame    = 0;
                gap_valid   = 1;
                cs_high_cnt = 0;
                done_cnt    = 0;
            end
            if (cs) cs_high_cnt++;
            if (debug_states == ST_DONE) done_cnt++;
        end
        prev_cs    = cs;
        prev_sck   = sck;
        prev_sdo   = sdo;
        prev_rst   = rst;
        prev_phase = debug_sck_halfs;
        prev_state = debug_states;
    end

    task automatic wait_load();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk12MHz);
            #1;
            if (debug_states == ST_LOAD) return;
        end
        check("load_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [11:0] v, input bit mid, input logic [11:0] mv);
        wait_load();
        value = v;
        exp_q.push_back({CFG, v});
        if (mid) begin
            repeat (12) @(posedge clk12MHz);
            #1;
            value = mv;
        end
    endtask

    initial begin
        rst   = 1'b0;
        value = 12'h000;
        repeat (64) @(posedge clk12MHz);
        #1;
        check("rst_hold_viol", rst_viol, 0);
        check("rst_cs", cs, 1);
        check("rst_sck", sck, 0);
        check("rst_sdo", sdo, 0);
        check("rst_state", debug_states, ST_IDLE);
        check("rst_phase", debug_sck_halfs, 0);

        value = 12'hA5C;
        rst   = 1'b1;
        send_frame(12'hA5C, 0, 12'h000);
        send_frame(12'h000, 0, 12'h000);
        send_frame(12'hFFF, 0, 12'h000);
        send_frame(12'h123, 1, 12'h456);
        send_frame(12'h456, 0, 12'h000);

        // Abort a frame mid-SHIFT with a one-clock reset
        send_frame(12'h3C3, 0, 12'h000);
        repeat (10) @(posedge clk12MHz);
        #1;
        check("pre_abort_state", debug_states, ST_SHIFT);
        rst = 1'b0;
        @(posedge clk12MHz);
        #1;
        rst = 1'b1;
        exp_q.delete();
        check("abort_cs", cs, 1);
        check("abort_sck", sck, 0);
        check("abort_state", debug_states, ST_IDLE);
        @(posedge clk12MHz);
        #1;
        check("e0_state", debug_states, ST_LOAD);
        value = 12'h7E1;
        exp_q.push_back({CFG, 12'h7E1});
        @(posedge clk12MHz);
        #1;
        check("e1_cs", cs, 0);
        check("e1_sdo", sdo, CFG[3]);
        @(posedge clk12MHz);
        #1;
        check("e2_sck", sck, 1);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk12MHz);
        #1;
        check("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
